// File: rtl/me_fetch_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : me_pkg                                                           |
// | Shared state encoding and default geometry for the ME fetch controller.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package me_pkg;

   localparam int ME_AWIDTH = 10;
   localparam int ME_BLK_W  = 16;
   localparam int ME_BLK_H  = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } fetch_state_t;

   // Counter width that stays legal for a dimension of 1.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/me_addr_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : me_addr_gen                                                      |
// | Block-raster address generator: row/col counters plus a row-start          |
// | accumulator stepped by a captured stride.                                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module me_addr_gen
   import me_pkg::*;
#(
   parameter  int AWIDTH  = ME_AWIDTH,
   parameter  int BLK_W   = ME_BLK_W,
   parameter  int BLK_H   = ME_BLK_H,
   localparam int c_ROW_W = cnt_width(BLK_H),
   localparam int c_COL_W = cnt_width(BLK_W)
)(
   input  logic               clock,
   input  logic               reset,
   input  logic               clear,
   input  logic               advance,
   input  logic [AWIDTH-1:0]  base,
   input  logic [AWIDTH-1:0]  stride,
   output logic [AWIDTH-1:0]  address,
   output logic [c_ROW_W-1:0] row,
   output logic [c_COL_W-1:0] col,
   output logic               row_done,
   output logic               blk_done
);

   localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(BLK_H - 1);
   localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(BLK_W - 1);

   logic [AWIDTH-1:0]  r_row_start;
   logic [AWIDTH-1:0]  r_stride;
   logic [c_ROW_W-1:0] r_row;
   logic [c_COL_W-1:0] r_col;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_row_start <= '0;
         r_stride    <= '0;
         r_row       <= '0;
         r_col       <= '0;
      end else if (clear) begin
         r_row_start <= base;
         r_stride    <= stride;
         r_row       <= '0;
         r_col       <= '0;
      end else if (advance) begin
         if (row_done) begin
            r_col       <= '0;
            r_row       <= blk_done ? '0 : r_row + c_ROW_W'(1);
            r_row_start <= r_row_start + r_stride;
         end else begin
            r_col <= r_col + c_COL_W'(1);
         end
      end
   end

   // Sum truncates to AWIDTH, so addresses wrap silently.
   assign address  = r_row_start + AWIDTH'(r_col);
   assign row      = r_row;
   assign col      = r_col;
   assign row_done = (r_col == c_COL_LAST);
   assign blk_done = row_done && (r_row == c_ROW_LAST);

endmodule
`default_nettype wire

// File: rtl/me_fetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : me_fetch_ctrl                                                    |
// | Lockstep block read sequencer for the dual-port pixel memory, presenting   |
// | q_a/q_b as a valid/ready stream. Option macro: ME_FETCH_TAG_EN (beat tags).|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module me_fetch_ctrl
   import me_pkg::*;
#(
   parameter int AWIDTH = ME_AWIDTH,
   parameter int BLK_W  = ME_BLK_W,
   parameter int BLK_H  = ME_BLK_H
)(
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        start,
   input  logic [AWIDTH-1:0]           base_a,
   input  logic [AWIDTH-1:0]           base_b,
   input  logic [AWIDTH-1:0]           stride_b,
   output logic [AWIDTH-1:0]           address_a,
   output logic [AWIDTH-1:0]           address_b,
   output logic                        wren_a,
   output logic                        wren_b,
   output logic                        out_valid,
   input  logic                        out_ready,
`ifdef ME_FETCH_TAG_EN
   output logic [cnt_width(BLK_H)-1:0] out_row,
   output logic [cnt_width(BLK_W)-1:0] out_col,
   output logic                        out_last,
`endif
   output logic                        busy,
   output logic                        done
);

   localparam int c_ROW_W = cnt_width(BLK_H);
   localparam int c_COL_W = cnt_width(BLK_W);

   fetch_state_t       r_state;
   logic               r_issue_valid;
   logic [AWIDTH-1:0]  r_issue_a, r_issue_b;
   logic [AWIDTH-1:0]  r_beat_a, r_beat_b;
   logic               w_advance, w_accept, w_issue, w_last;
   logic [AWIDTH-1:0]  w_gen_a, w_gen_b;
   logic [c_ROW_W-1:0] w_row_a, w_row_b;
   logic [c_COL_W-1:0] w_col_a, w_col_b;
   logic               w_row_done_a, w_row_done_b, w_blk_done_a, w_blk_done_b;
   logic               w_unused_gen;
`ifdef ME_FETCH_TAG_EN
   logic [c_ROW_W-1:0] r_tag_row;
   logic [c_COL_W-1:0] r_tag_col;
   logic               r_tag_last;
`endif

   assign w_advance = !out_valid || out_ready;
   assign w_accept  = (r_state == IDLE) && start;
   assign w_issue   = (r_state == RUN) && w_advance;
   assign w_last    = w_blk_done_a;

   me_addr_gen #(.AWIDTH(AWIDTH), .BLK_W(BLK_W), .BLK_H(BLK_H)) u_gen_a (
      .clock(clock), .reset(reset), .clear(w_accept), .advance(w_issue),
      .base(base_a), .stride(AWIDTH'(BLK_W)), .address(w_gen_a),
      .row(w_row_a), .col(w_col_a), .row_done(w_row_done_a), .blk_done(w_blk_done_a)
   );

   me_addr_gen #(.AWIDTH(AWIDTH), .BLK_W(BLK_W), .BLK_H(BLK_H)) u_gen_b (
      .clock(clock), .reset(reset), .clear(w_accept), .advance(w_issue),
      .base(base_b), .stride(stride_b), .address(w_gen_b),
      .row(w_row_b), .col(w_col_b), .row_done(w_row_done_b), .blk_done(w_blk_done_b)
   );

`ifdef ME_FETCH_TAG_EN
   assign w_unused_gen = ^{w_row_done_a, w_row_done_b, w_blk_done_b, w_row_b, w_col_b};
`else
   assign w_unused_gen = ^{w_row_done_a, w_row_done_b, w_blk_done_b, w_row_b, w_col_b,
                           w_row_a, w_col_a};
`endif

   // A stalled beat re-presents its own address so the registered read keeps q stable.
   assign address_a = w_advance ? r_issue_a : r_beat_a;
   assign address_b = w_advance ? r_issue_b : r_beat_b;
   assign wren_a    = 1'b0;
   assign wren_b    = 1'b0;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state       <= IDLE;
         r_issue_valid <= 1'b0;
         r_issue_a     <= '0;
         r_issue_b     <= '0;
         r_beat_a      <= '0;
         r_beat_b      <= '0;
         out_valid     <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
`ifdef ME_FETCH_TAG_EN
         r_tag_row     <= '0;
         r_tag_col     <= '0;
         r_tag_last    <= 1'b0;
         out_row       <= '0;
         out_col       <= '0;
         out_last      <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_state <= RUN;
                  busy    <= 1'b1;
               end
            end
            RUN, DRAIN: begin
               if (w_advance) begin
                  out_valid <= r_issue_valid;
                  r_beat_a  <= r_issue_a;
                  r_beat_b  <= r_issue_b;
`ifdef ME_FETCH_TAG_EN
                  out_row   <= r_tag_row;
                  out_col   <= r_tag_col;
                  out_last  <= r_tag_last;
`endif
                  if (r_state == RUN) begin
                     r_issue_valid <= 1'b1;
                     r_issue_a     <= w_gen_a;
                     r_issue_b     <= w_gen_b;
`ifdef ME_FETCH_TAG_EN
                     r_tag_row     <= w_row_a;
                     r_tag_col     <= w_col_a;
                     r_tag_last    <= w_last;
`endif
                     if (w_last) r_state <= DRAIN;
                  end else begin
                     r_issue_valid <= 1'b0;
`ifdef ME_FETCH_TAG_EN
                     r_tag_last    <= 1'b0;
`endif
                     // Final beat leaves the output register on this edge.
                     if (out_valid && !r_issue_valid) begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= IDLE;
                     end
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_me_fetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_me_fetch_ctrl                                                 |
// | Scoreboard bench for me_fetch_ctrl with a word=address memory model.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_me_fetch_ctrl;
   import me_pkg::*;

   localparam int AW = 10;
   localparam int BW = 4;
   localparam int BH = 2;
   localparam int NB = BW * BH;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          out_ready = 1'b1;
   logic [AW-1:0] base_a = '0, base_b = '0, stride_b = '0;
   logic [AW-1:0] address_a, address_b;
   logic          wren_a, wren_b, out_valid, busy, done;
`ifdef ME_FETCH_TAG_EN
   logic [cnt_width(BH)-1:0] out_row;
   logic [cnt_width(BW)-1:0] out_col;
   logic                     out_last;
`endif

   logic [AW-1:0] mem [0:(1<<AW)-1];
   logic [AW-1:0] q_a, q_b;

   typedef struct {
      logic [AW-1:0] a;
      logic [AW-1:0] b;
      int            row;
      int            col;
      bit            last;
   } beat_t;

   beat_t exp_q[$];
   int    checks = 0, errors = 0;
   int    beats_acc = 0, last_acc = 0, stall_cnt = 0, ready_mode = 0;
   bit    pend_done = 1'b0;

   always #5 clock = ~clock;

   me_fetch_ctrl #(.AWIDTH(AW), .BLK_W(BW), .BLK_H(BH)) dut (
      .clock(clock), .reset(reset), .start(start),
      .base_a(base_a), .base_b(base_b), .stride_b(stride_b),
      .address_a(address_a), .address_b(address_b),
      .wren_a(wren_a), .wren_b(wren_b),
      .out_valid(out_valid), .out_ready(out_ready),
`ifdef ME_FETCH_TAG_EN
      .out_row(out_row), .out_col(out_col), .out_last(out_last),
`endif
      .busy(busy), .done(done)
   );

   initial for (int i = 0; i < (1 << AW); i++) mem[i] = AW'(i);

   always @(posedge clock) begin
      q_a <= mem[address_a];
      q_b <= mem[address_b];
   end

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every presented beat must match the queue head; acceptance pops it.
   always @(negedge clock) begin
      if (reset) begin
         exp_q.delete();
         pend_done = 1'b0;
      end else begin
         check("done", done, pend_done);
         if (pend_done) check("busy_at_done", busy, 0);
         pend_done = 1'b0;
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               check("extra_beat", out_valid, 0);
            end else begin
               check("q_a", q_a, exp_q[0].a);
               check("q_b", q_b, exp_q[0].b);
`ifdef ME_FETCH_TAG_EN
               check("out_row", out_row, exp_q[0].row);
               check("out_col", out_col, exp_q[0].col);
               check("out_last", out_last, exp_q[0].last);
`endif
               if (!out_ready) begin
                  check("stall_addr_a", address_a, exp_q[0].a);
                  check("stall_addr_b", address_b, exp_q[0].b);
               end else begin
                  pend_done = exp_q[0].last;
                  void'(exp_q.pop_front());
                  beats_acc++;
               end
            end
         end
      end
   end

   // Consumer: always ready, random, or 3-cycle stalls on beats 3 and 6.
   always @(posedge clock) begin
      #1;
      if (beats_acc != last_acc) begin
         last_acc  = beats_acc;
         stall_cnt = 0;
      end
      case (ready_mode)
         0: out_ready = 1'b1;
         1: out_ready = ($urandom_range(3) != 0);
         default: begin
            if (out_valid && ((beats_acc % NB) == 2 || (beats_acc % NB) == 5) && stall_cnt < 3) begin
               out_ready = 1'b0;
               stall_cnt++;
            end else begin
               out_ready = 1'b1;
            end
         end
      endcase
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Requests a block and pushes its expected beats, raster order, mod 2**AW.
   task automatic issue(input logic [AW-1:0] ba, input logic [AW-1:0] bb, input logic [AW-1:0] sb);
      beat_t e;
      start = 1'b1; base_a = ba; base_b = bb; stride_b = sb;
      for (int r = 0; r < BH; r++) begin
         for (int c = 0; c < BW; c++) begin
            e.a    = AW'(int'(ba) + r * BW + c);
            e.b    = AW'(int'(bb) + r * int'(sb) + c);
            e.row  = r;
            e.col  = c;
            e.last = (r == BH - 1) && (c == BW - 1);
            exp_q.push_back(e);
         end
      end
      tick();
      start = 1'b0;
      base_a = AW'($urandom); base_b = AW'($urandom); stride_b = AW'($urandom);
   endtask

   task automatic check_latency(input logic [AW-1:0] ba, input logic [AW-1:0] bb);
      check("busy_after_start", busy, 1);
      check("valid_edge0", out_valid, 0);
      tick();
      check("valid_edge1", out_valid, 0);
      check("first_addr_a", address_a, ba);
      check("first_addr_b", address_b, bb);
      tick();
      check("valid_edge2", out_valid, 1);
   endtask

   task automatic wait_done();
      for (int i = 0; i < 400; i++) begin
         if (done) return;
         tick();
      end
      check("done_timeout", done, 1);
   endtask

   task automatic run_block(input logic [AW-1:0] ba, input logic [AW-1:0] bb, input logic [AW-1:0] sb);
      issue(ba, bb, sb);
      check_latency(ba, bb);
      wait_done();
   endtask

   initial begin
      logic [AW-1:0] ra, rb, rs;
      repeat (3) tick();
      check("rst_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_addr_a", address_a, 0);
      check("rst_addr_b", address_b, 0);
      check("wren", {wren_a, wren_b}, 0);
`ifdef ME_FETCH_TAG_EN
      check("rst_tags", {out_row, out_col, out_last}, 0);
`endif
      reset = 1'b0;
      tick();

      ready_mode = 0;
      run_block(10'h010, 10'h100, 10'd8);
      tick();

      ready_mode = 2;
      run_block(10'h010, 10'h100, 10'd8);
      tick();

      ready_mode = 0;
      run_block(10'h010, 10'h3FE, 10'd4);
      tick();

      // Start pulse mid-run must be ignored.
      ready_mode = 1;
      issue(10'h020, 10'h200, 10'd16);
      tick(); tick(); tick();
      start = 1'b1; base_a = 10'h155; base_b = 10'h2AA; stride_b = 10'd3;
      tick();
      start = 1'b0;
      wait_done();
      repeat (4) tick();

      // Reset after beat 5.
      ready_mode = 0;
      beats_acc = 0;
      issue(10'h040, 10'h080, 10'd12);
      for (int i = 0; i < 100 && beats_acc < 5; i++) tick();
      check("reached_beat5", beats_acc, 5);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("midrst_valid", out_valid, 0);
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_addr_a", address_a, 0);
      check("midrst_addr_b", address_b, 0);
      run_block(10'h040, 10'h080, 10'd12);
      tick();

      // Back-to-back: start on the done cycle.
      run_block(10'h030, 10'h130, 10'd5);
      run_block(10'h0F0, 10'h000, 10'd0);
      tick();

      ready_mode = 1;
      for (int n = 0; n < 12; n++) begin
         ra = AW'($urandom); rb = AW'($urandom); rs = AW'($urandom_range(40));
         run_block(ra, rb, rs);
         if ($urandom_range(1) == 1) tick();
      end

      ready_mode = 0;
      repeat (5) tick();
      check("queue_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/me_fetch_ctrl.md
Name: me_fetch_ctrl

Overview:
- Read sequencer for the dual-port pixel memory (registered read, 1-cycle latency).
- On a start pulse it streams one BLK_W x BLK_H block from port A (current block) and the co-located block from port B (search-window region) in lockstep.
- Emits a valid/ready stream that pairs the memory outputs q_a/q_b to the SAD datapath.
- Drives the memory address ports; write enables are held 0.

Parameters:
- AWIDTH, 10, memory address width; matches the memory instance.
- BLK_W, 16, words per block row.
- BLK_H, 16, rows per block.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request; sampled only in IDLE.
- base_a  in  AWIDTH  port-A block origin; captured on an accepted start.
- base_b  in  AWIDTH  port-B block origin; captured on an accepted start.
- stride_b  in  AWIDTH  port-B row pitch in words; captured on an accepted start.
- address_a  out  AWIDTH  to memory address_a.
- address_b  out  AWIDTH  to memory address_b.
- wren_a, wren_b  out  1 each  constant 0.
- out_valid  out  1  q_a/q_b hold the current beat.
- out_ready  in  1  consumer accepts the beat.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset values: address_a=0, address_b=0, out_valid=0, busy=0, done=0, state=IDLE, row/col counters=0.
- States and transitions:
  - IDLE: start=1 captures base_a, base_b and stride_b, clears row/col, sets busy, enters RUN.
  - RUN: issues addresses; moves to DRAIN after the last address (row=BLK_H-1, col=BLK_W-1) is issued and accepted.
  - DRAIN: waits for the final beat to be accepted, then pulses done, clears busy, returns to IDLE.
- Address formulas:
  - address_a = base_a + row*BLK_W + col.
  - address_b = base_b + row*stride_b + col.
  - Both are computed incrementally with row-start accumulators (no multiplier) and truncated mod 2**AWIDTH, so wrap-around is silent.
- Timing: start sampled at edge 0 -> first address driven after edge 1 -> out_valid=1 after edge 2 (q_a/q_b valid on the same cycle).
- Issue/advance rule (advance = !out_valid || out_ready):
  - Counters and addresses step only when advance=1 in RUN.
  - While out_valid=1 and out_ready=0, the addresses are held. The memory re-reads the same location, so q_a/q_b stay stable.
- out_valid is set on the cycle after an address is issued, and stays set until that beat is accepted.
- Beat count is exactly BLK_W*BLK_H. col runs 0..BLK_W-1 and wraps to 0 with row+1.
- done fires the cycle after the last out_valid&&out_ready. busy falls at the same edge that raises done.
- Back-to-back requests: a start asserted on the done cycle is accepted; the new first address is driven after the next edge.
- start while busy is ignored; there is no queueing.
- stride_b=0 is legal: every port-B row re-reads the same row.
- Reset asserted mid-operation aborts at once to the reset values. No done pulse; the partial stream is discarded.

Optional Feature:
- Macro: ME_FETCH_TAG_EN.
- Defined:
  - Adds outputs out_row [$clog2(BLK_H)] and out_col [$clog2(BLK_W)], the coordinates of the current beat, plus out_last (1 on the final beat).
  - All three are aligned with out_valid, held during stalls, and 0 at reset.
- Undefined: these ports and their registers are absent; all other behaviour is identical.

Decomposition:
- Shared package me_pkg:
  - State encoding typedef fetch_state_t (IDLE, RUN, DRAIN).
  - Default constants ME_BLK_W=16, ME_BLK_H=16, ME_AWIDTH=10.
- One sub-module, me_addr_gen:
  - Row/col counters with stride accumulators.
  - Inputs: advance and clear. Outputs: address, row_done, blk_done.
  - Instantiated twice: port A with stride BLK_W, port B with stride_b.

Test Plan:
- Basic stream:
  - Stimulus: BLK_W=4, BLK_H=2, base_a=0x010, base_b=0x100, stride_b=8, out_ready=1, memory preloaded with word = address.
  - Response:
    - 8 beats, q_a = 0x10..0x13 then 0x14..0x17.
    - q_b = 0x100..0x103 then 0x108..0x10B.
    - First out_valid exactly 2 cycles after start.
    - done 1 cycle after beat 8.
- Backpressure:
  - Stimulus: same setup; out_ready=0 on beats 3 and 6 for 3 cycles each.
  - Response: the address and q pair are stable while stalled; no beat is lost or duplicated; total 8 accepted beats.
- Wrap-around:
  - Stimulus: base_b=0x3FE, stride_b=4, AWIDTH=10.
  - Response: address_b sequence 0x3FE, 0x3FF, 0x000, 0x001, then 0x002.
- Ignored start:
  - Stimulus: start pulsed mid-RUN with different bases.
  - Response: the stream is unchanged; exactly one done pulse.
- Reset mid-op:
  - Stimulus: reset=1 on beat 5.
  - Response: next cycle out_valid=0, busy=0, address_a=address_b=0, no done pulse; a following start produces a full 8-beat stream.
- Back-to-back plus tags (with ME_FETCH_TAG_EN defined):
  - Stimulus: start asserted on the done cycle.
  - Response: the second stream begins 2 cycles later; out_last=1 only on the final beat of each stream, with (out_row,out_col)=(1,3).
